axis_video_out: RTL

//  Reader (master-side consumer) for the pixel-clock end of the 24-bit AXI-Stream CDC FIFO.

---
 rtl/axis_video_pkg.sv | 29 ++
 rtl/axis_video_out_timing.sv | 66 ++++++
 rtl/axis_video_out.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/axis_video_pkg.sv
// ---------------------------------------------------------------------------
// axis_video_pkg
// Shared types and timing helpers for the pixel-clock video reader.
//   vid_state_t  : reader state (PREFILL waits for FIFO fill, RUN streams)
//   line_total() : total length of a line/frame from its four timing segments
//   DEF_*        : default 1280x720 @60 Hz timing (pixel clocks / lines)
// ---------------------------------------------------------------------------
package axis_video_pkg;

    typedef enum logic {
        PREFILL = 1'b0,
        RUN     = 1'b1
    } vid_state_t;

    localparam int DEF_H_ACTIVE = 1280;
    localparam int DEF_H_FP     = 110;
    localparam int DEF_H_SYNC   = 40;
    localparam int DEF_H_BP     = 220;
    localparam int DEF_V_ACTIVE = 720;
    localparam int DEF_V_FP     = 5;
    localparam int DEF_V_SYNC   = 5;
    localparam int DEF_V_BP     = 20;

    function automatic int line_total(input int active, input int fp,
                                      input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/axis_video_out_timing.sv
// ---------------------------------------------------------------------------
// vid_timing_gen
// Free-running raster counters. h_cnt runs 0..H_TOTAL-1, v_cnt advances on
// each h wrap and runs 0..V_TOTAL-1. All outputs are combinational decodes
// of the counter registers (active-high, polarity applied by the caller).
// Ports:
//   clk, rst_n  : pixel clock, asynchronous active-low reset
//   active      : current pixel lies in the visible area
//   hsync_act   : current pixel lies in the horizontal sync pulse
//   vsync_act   : current line lies in the vertical sync pulse
//   frame_end   : current pixel is the last pixel of the frame
// ---------------------------------------------------------------------------
module vid_timing_gen
    import axis_video_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic clk,
    input  logic rst_n,
    output logic active,
    output logic hsync_act,
    output logic vsync_act,
    output logic frame_end
);

    localparam int H_TOTAL = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [15:0] H_LAST   = 16'(H_TOTAL - 1);
    localparam logic [15:0] V_LAST   = 16'(V_TOTAL - 1);
    localparam logic [15:0] H_ACT    = 16'(H_ACTIVE);
    localparam logic [15:0] V_ACT    = 16'(V_ACTIVE);
    localparam logic [15:0] HS_START = 16'(H_ACTIVE + H_FP);
    localparam logic [15:0] HS_END   = 16'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [15:0] VS_START = 16'(V_ACTIVE + V_FP);
    localparam logic [15:0] VS_END   = 16'(V_ACTIVE + V_FP + V_SYNC);

    logic [15:0] h_cnt;
    logic [15:0] v_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? 16'd0 : v_cnt + 16'd1;
        end else begin
            h_cnt <= h_cnt + 16'd1;
        end
    end

    assign active    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign hsync_act = (h_cnt >= HS_START) && (h_cnt < HS_END);
    // Vertical sync covers whole lines, so it depends on v_cnt only.
    assign vsync_act = (v_cnt >= VS_START) && (v_cnt < VS_END);
    assign frame_end = (h_cnt == H_LAST) && (v_cnt == V_LAST);

endmodule

// File: rtl/axis_video_out.sv
// ---------------------------------------------------------------------------
// axis_video_out
// Pixel-clock reader for the 24-bit AXI-Stream CDC FIFO. Waits in PREFILL
// until the FIFO holds START_LEVEL words at a frame boundary, then streams
// one pixel per active clock as raster video. An underrun blanks the rest of
// the frame and sends the reader back to PREFILL at the frame boundary.
//
// Handshake: a word moves from the FIFO when m_axis_tvalid && m_axis_tready
// are both high on a rising m_axis_aclk edge. m_axis_tready is decoded from
// registers only and never depends on m_axis_tvalid. tready high with tvalid
// low is an underrun.
//
// Ports:
//   m_axis_aclk, m_axis_aresetn : pixel clock, async active-low reset
//   m_axis_tvalid/tready/tdata  : FIFO read port
//   axis_rd_data_count          : FIFO fill level in words
//   vid_data/de/hsync/vsync     : registered raster video (1-cycle latency)
//   vid_running                 : reader state, high in RUN
//   vid_underrun                : sticky underrun flag, cleared by reset only
//   vid_underrun_cnt            : saturating underrun pixel count, present
//                                 only when AXIS_VIDEO_OUT_UNDERRUN_CNT_EN
//                                 is defined
// ---------------------------------------------------------------------------
module axis_video_out
    import axis_video_pkg::*;
#(
    parameter int   DATA_WIDTH  = 24,
    parameter int   COUNT_WIDTH = 14,
    parameter int   START_LEVEL = 512,
    parameter int   H_ACTIVE    = DEF_H_ACTIVE,
    parameter int   H_FP        = DEF_H_FP,
    parameter int   H_SYNC      = DEF_H_SYNC,
    parameter int   H_BP        = DEF_H_BP,
    parameter int   V_ACTIVE    = DEF_V_ACTIVE,
    parameter int   V_FP        = DEF_V_FP,
    parameter int   V_SYNC      = DEF_V_SYNC,
    parameter int   V_BP        = DEF_V_BP,
    parameter logic HSYNC_POL   = 1'b1,
    parameter logic VSYNC_POL   = 1'b1
) (
    input  logic                   m_axis_aclk,
    input  logic                   m_axis_aresetn,
    input  logic                   m_axis_tvalid,
    output logic                   m_axis_tready,
    input  logic [DATA_WIDTH-1:0]  m_axis_tdata,
    input  logic [COUNT_WIDTH-1:0] axis_rd_data_count,
    output logic [DATA_WIDTH-1:0]  vid_data,
    output logic                   vid_de,
    output logic                   vid_hsync,
    output logic                   vid_vsync,
    output logic                   vid_running,
`ifdef AXIS_VIDEO_OUT_UNDERRUN_CNT_EN
    output logic [15:0]            vid_underrun_cnt,
`endif
    output logic                   vid_underrun
);

    localparam logic [COUNT_WIDTH-1:0] START_LVL = COUNT_WIDTH'(START_LEVEL);

    logic       active;
    logic       hsync_act;
    logic       vsync_act;
    logic       frame_end;

    vid_state_t state;
    vid_state_t state_nxt;
    logic       frame_bad;
    logic       frame_bad_nxt;
    logic       pop;
    logic       underrun;

    vid_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk       (m_axis_aclk),
        .rst_n     (m_axis_aresetn),
        .active    (active),
        .hsync_act (hsync_act),
        .vsync_act (vsync_act),
        .frame_end (frame_end)
    );

    // frame_bad stops further pops after an underrun until the frame ends.
    assign m_axis_tready = (state == RUN) && active && !frame_bad;
    assign pop           = m_axis_tready && m_axis_tvalid;
    assign underrun      = m_axis_tready && !m_axis_tvalid;
    assign vid_running   = (state == RUN);

    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            state     <= PREFILL;
            frame_bad <= 1'b0;
        end else begin
            state     <= state_nxt;
            frame_bad <= frame_bad_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        frame_bad_nxt = frame_bad;
        case (state)
            PREFILL: begin
                frame_bad_nxt = 1'b0;
                if (frame_end && (axis_rd_data_count >= START_LVL)) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (frame_end) begin
                    // A bad frame is never carried into the next one.
                    frame_bad_nxt = 1'b0;
                    if (frame_bad || underrun) begin
                        state_nxt = PREFILL;
                    end
                end else if (underrun) begin
                    frame_bad_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt     = PREFILL;
                frame_bad_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            vid_data     <= '0;
            vid_de       <= 1'b0;
            vid_hsync    <= ~HSYNC_POL;
            vid_vsync    <= ~VSYNC_POL;
            vid_underrun <= 1'b0;
        end else begin
            vid_data  <= pop ? m_axis_tdata : '0;
            vid_de    <= active;
            vid_hsync <= hsync_act ? HSYNC_POL : ~HSYNC_POL;
            vid_vsync <= vsync_act ? VSYNC_POL : ~VSYNC_POL;
            if (underrun) begin
                vid_underrun <= 1'b1;
            end
        end
    end

`ifdef AXIS_VIDEO_OUT_UNDERRUN_CNT_EN
    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            vid_underrun_cnt <= '0;
        end else if (underrun && (vid_underrun_cnt != 16'hFFFF)) begin
            vid_underrun_cnt <= vid_underrun_cnt + 16'd1;
        end
    end
`endif

endmodule
